// File: rtl/aes_iter_round_engine.sv
// Iterative AES encryption engine. One shared round unit is reused for every
// round: the A phase registers the T-table (or plain S-box) lookups of the
// state, the B phase combines them with ShiftRows selection and the round key.
// Round keys come from an external key-schedule store addressed by rk_idx.
module aes_iter_round_engine #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         busy
);

  localparam int         DATA_W     = 128;
  localparam int         NR         = KEY_BITS / 32 + 6;
  localparam logic [3:0] NR_IDX     = 4'(NR);
  localparam bit         SINGLE_RND = (NR == 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_iter_round_engine: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {IDLE, RND_A, RND_B, FIN_A, FIN_B, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns contribution of a substituted byte sitting in the given row.
  function automatic logic [31:0] t_word(input logic [7:0] s, input logic [1:0] row);
    logic [7:0] s2;
    logic [7:0] s3;
    s2 = xtime(s);
    s3 = s2 ^ s;
    case (row)
      2'd0:    return {s2, s, s, s3};
      2'd1:    return {s3, s2, s, s};
      2'd2:    return {s, s3, s2, s};
      default: return {s, s, s3, s2};
    endcase
  endfunction

  state_t            state;
  logic [3:0]        rnd;
  logic [3:0]        rnd_nxt;
  logic [DATA_W-1:0] st_p0;
  logic [31:0]       t_p1  [4][4];
  logic [31:0]       t_rnd [4][4];
  logic [31:0]       t_fin [4][4];
  logic [DATA_W-1:0] mix_rnd;
  logic [DATA_W-1:0] mix_fin;

  assign rnd_nxt  = rnd + 4'd1;
  assign rk_idx   = rnd;
  assign busy     = (state != IDLE);
  assign in_ready = rst && (state == IDLE);

  // Lookup of every state byte: [column][row], full T word or bare S-box byte.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t_rnd[c][r] = t_word(sbox(st_p0[DATA_W-1-32*c-8*r -: 8]), 2'(r));
        t_fin[c][r] = {24'h0, sbox(st_p0[DATA_W-1-32*c-8*r -: 8])};
      end
    end
  end

  // ShiftRows selection of the registered lookups for middle and final rounds.
  always_comb begin
    mix_rnd = {t_p1[0][0] ^ t_p1[1][1] ^ t_p1[2][2] ^ t_p1[3][3],
               t_p1[0][3] ^ t_p1[1][0] ^ t_p1[2][1] ^ t_p1[3][2],
               t_p1[0][2] ^ t_p1[1][3] ^ t_p1[2][0] ^ t_p1[3][1],
               t_p1[0][1] ^ t_p1[1][2] ^ t_p1[2][3] ^ t_p1[3][0]};
    mix_fin = {t_p1[0][0][7:0], t_p1[1][1][7:0], t_p1[2][2][7:0], t_p1[3][3][7:0],
               t_p1[1][0][7:0], t_p1[2][1][7:0], t_p1[3][2][7:0], t_p1[0][3][7:0],
               t_p1[2][0][7:0], t_p1[3][1][7:0], t_p1[0][2][7:0], t_p1[1][3][7:0],
               t_p1[3][0][7:0], t_p1[0][1][7:0], t_p1[1][2][7:0], t_p1[2][3][7:0]};
  end

  // Round-counter FSM with the state register, lookup register and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      st_p0     <= '0;
      t_p1      <= '{default: '0};
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_p0 <= in_data ^ rk;
            rnd   <= 4'd1;
            state <= SINGLE_RND ? FIN_A : RND_A;
          end
        end
        // A -> B boundary: lookups of the current state are captured.
        RND_A: begin
          t_p1  <= t_rnd;
          state <= RND_B;
        end
        // B -> A boundary: next state word formed with round key rnd.
        RND_B: begin
          st_p0 <= mix_rnd ^ rk;
          rnd   <= rnd_nxt;
          state <= (rnd_nxt == NR_IDX) ? FIN_A : RND_A;
        end
        FIN_A: begin
          t_p1  <= t_fin;
          state <= FIN_B;
        end
        // Final round has no MixColumns; result goes straight to the output register.
        FIN_B: begin
          out_data  <= mix_fin ^ rk;
          out_valid <= 1'b1;
          rnd       <= 4'd0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
